proj_fm_scanner: RTL and testbench
==================================

PROJ_FM_SCANNER -- requirements
Module: proj_fm_scanner

Interface
REQ-001 SHALL have parameter FM_BUFFER_SIZE, default proj_pkg::FM_BUFFER_SIZE: bits per FM buffer.
REQ-002 SHALL have parameter FRAG_LEN, default proj_pkg::FM_EXTENDER_FRAG_LEN_BITS: fragment width in bits.
REQ-003 SHALL have parameter SIGNED_INDICE_LEN, default proj_pkg::SIGNED_INDICE_LEN: frag_idx width, two's complement.
REQ-004 SHALL have parameter OVERLAP, default proj_pkg::FM_SCAN_OVERLAP (2): bits reread from the previous buffer tail through a negative index.
REQ-005 SHALL have parameter STRIDE, default proj_pkg::FM_SCAN_STRIDE (1): index step between windows, 1 to FRAG_LEN.
REQ-006 SHALL have ports, clock and reset first (one clock; reset asynchronous, active-low):
- in_clk  input  1  sole clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  one-cycle pulse: proj_fm buffer fill complete.
- out_chg_idx  output  1  buffer-swap pulse to proj_fm chg_idx.
- out_frag_idx  output  SIGNED_INDICE_LEN  window start index to proj_fm frag_idx.
- in_frag  input  FRAG_LEN  proj_fm out_rdata.
- out_kmer  output  FRAG_LEN  captured window.
- out_kmer_pos  output  SIGNED_INDICE_LEN  index of out_kmer.
- out_kmer_valid  output  1  out_kmer and out_kmer_pos valid.
- in_kmer_ready  input  1  downstream accepts the window.
- out_last  output  1  qualifies the final window of a scan.
- out_busy  output  1  scan in progress.
- out_overrun  output  1  sticky: in_start arrived while busy.

Function
REQ-007 SHALL implement FSM states IDLE, SWAP, ADDR, WAIT, OUT.
REQ-008 IDLE: on in_start=1, SHALL go to SWAP; otherwise SHALL stay.
REQ-009 SWAP: SHALL drive out_chg_idx=1 for exactly this one cycle, load idx = -OVERLAP, then go to ADDR.
REQ-010 ADDR: SHALL drive out_frag_idx=idx; next state WAIT.
REQ-011 WAIT: SHALL hold out_frag_idx; proj_fm read latency is 1 cycle; SHALL capture in_frag into out_kmer and idx into out_kmer_pos at the end of WAIT; next state OUT.
REQ-012 OUT: SHALL assert out_kmer_valid, and SHALL hold out_kmer, out_kmer_pos and out_last stable until in_kmer_ready=1.
REQ-013 A transfer SHALL occur when out_kmer_valid and in_kmer_ready are both 1 on a rising edge.
REQ-014 On transfer with out_last=0: SHALL set idx += STRIDE and go to ADDR. On transfer with out_last=1: SHALL go to IDLE.
REQ-015 out_last SHALL be 1 iff idx + STRIDE > FM_BUFFER_SIZE - FRAG_LEN (signed compare, SIGNED_INDICE_LEN+1 bits, no wrap).
REQ-016 Latency: in_start to first out_kmer_valid SHALL be 4 cycles. Each later window SHALL follow 3 cycles after the previous transfer when ready is held at 1.
REQ-017 out_busy SHALL be 1 in every state except IDLE.
REQ-018 in_start while out_busy=1 SHALL be ignored for sequencing and SHALL set out_overrun; out_overrun SHALL clear only on reset.
REQ-019 in_kmer_ready outside OUT SHALL have no effect.
REQ-020 out_frag_idx SHALL equal idx in ADDR, WAIT and OUT, and SHALL be 0 in IDLE and SWAP.

Reset
REQ-021 in_rst_n=0 SHALL asynchronously force state IDLE, idx=0, and set every output to 0: out_chg_idx, out_frag_idx, out_kmer, out_kmer_pos, out_kmer_valid, out_last, out_busy, out_overrun.
REQ-022 Reset mid-scan SHALL abandon the scan. No out_chg_idx pulse SHALL be issued until the next in_start after reset release.

Structure
REQ-023 FM_SCAN_OVERLAP, FM_SCAN_STRIDE and the scanner state enum typedef SHALL live in proj_pkg.
REQ-024 The block SHALL be a single module with no sub-modules. The index and last-window arithmetic SHALL sit inline in the module.

Verification (bench parameters: FM_BUFFER_SIZE=16, FRAG_LEN=8, OVERLAP=2, STRIDE=2, behavioural proj_fm model)
REQ-025 in_start pulse with ready=1 -> one out_chg_idx pulse at cycle 1; windows at pos -2,0,2,4,6,8 with out_last only at 8; first valid at cycle 4; out_busy falls after pos 8.
REQ-026 Model buffer = 16'hA5C3, previous tail bits = 2'b10 -> out_kmer at each pos equals the model slice bit-exactly, including pos -2.
REQ-027 ready held 0 for 5 cycles at pos 4 -> valid, out_kmer and out_kmer_pos stay stable all 5 cycles; scan resumes at pos 6 three cycles after the transfer.
REQ-028 second in_start at pos 2 -> out_overrun=1 and stays 1; exactly 6 windows and no extra out_chg_idx.
REQ-029 in_rst_n=0 for one cycle at pos 4 -> all outputs 0 immediately; next in_start restarts at pos -2.
REQ-030 STRIDE=8 run -> windows at pos -2 and 6, out_last at 6.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared constants and types for the proj_fm buffer and its window scanner.
package proj_pkg;

    localparam int FM_BUFFER_SIZE            = 64;
    localparam int FM_EXTENDER_FRAG_LEN_BITS = 16;
    localparam int SIGNED_INDICE_LEN         = 8;
    localparam int FM_SCAN_OVERLAP           = 2;
    localparam int FM_SCAN_STRIDE            = 1;

    typedef enum logic [2:0] {
        SCAN_IDLE,
        SCAN_SWAP,
        SCAN_ADDR,
        SCAN_WAIT,
        SCAN_OUT
    } scan_state_e;

endpackage

// File: rtl/proj_fm_scanner.sv
// Walks a freshly filled proj_fm buffer in fixed-stride windows, starting OVERLAP
// bits into the previous buffer's tail, and hands each window downstream.
module proj_fm_scanner #(
    parameter int FM_BUFFER_SIZE    = proj_pkg::FM_BUFFER_SIZE,
    parameter int FRAG_LEN          = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
    parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
    parameter int OVERLAP           = proj_pkg::FM_SCAN_OVERLAP,
    parameter int STRIDE            = proj_pkg::FM_SCAN_STRIDE
) (
    input  logic                         in_clk,
    input  logic                         in_rst_n,
    input  logic                         in_start,
    output logic                         out_chg_idx,
    output logic [SIGNED_INDICE_LEN-1:0] out_frag_idx,
    input  logic [FRAG_LEN-1:0]          in_frag,
    output logic [FRAG_LEN-1:0]          out_kmer,
    output logic [SIGNED_INDICE_LEN-1:0] out_kmer_pos,
    output logic                         out_kmer_valid,
    input  logic                         in_kmer_ready,
    output logic                         out_last,
    output logic                         out_busy,
    output logic                         out_overrun
);
    import proj_pkg::*;

    localparam int L = SIGNED_INDICE_LEN;
    localparam logic signed [L:0]   LAST_LIMIT = (L+1)'(FM_BUFFER_SIZE - FRAG_LEN);
    localparam logic signed [L:0]   STRIDE_EXT = (L+1)'(STRIDE);
    localparam logic signed [L-1:0] IDX_START  = L'(-OVERLAP);

    scan_state_e state_q, state_d;
    logic signed [L-1:0] idx_q, idx_d;
    logic [FRAG_LEN-1:0] kmer_q, kmer_d;
    logic [L-1:0]        kmer_pos_q, kmer_pos_d;
    logic                overrun_q, overrun_d;

    // One extra bit so idx + STRIDE near the top of the index range cannot wrap.
    logic signed [L:0] idx_step;
    logic              is_last;

    always_comb begin
        idx_step = {idx_q[L-1], idx_q};
        idx_step = idx_step + STRIDE_EXT;
        is_last  = (idx_step > LAST_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        kmer_d     = kmer_q;
        kmer_pos_d = kmer_pos_q;
        overrun_d  = overrun_q | (in_start && (state_q != SCAN_IDLE));

        case (state_q)
            SCAN_IDLE: begin
                if (in_start) begin
                    state_d = SCAN_SWAP;
                end
            end
            SCAN_SWAP: begin
                idx_d   = IDX_START;
                state_d = SCAN_ADDR;
            end
            SCAN_ADDR: begin
                state_d = SCAN_WAIT;
            end
            SCAN_WAIT: begin
                kmer_d     = in_frag;
                kmer_pos_d = idx_q;
                state_d    = SCAN_OUT;
            end
            SCAN_OUT: begin
                if (in_kmer_ready) begin
                    if (is_last) begin
                        state_d = SCAN_IDLE;
                    end else begin
                        idx_d   = idx_step[L-1:0];
                        state_d = SCAN_ADDR;
                    end
                end
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= SCAN_IDLE;
            idx_q      <= '0;
            kmer_q     <= '0;
            kmer_pos_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            kmer_q     <= kmer_d;
            kmer_pos_q <= kmer_pos_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        out_chg_idx    = (state_q == SCAN_SWAP);
        out_busy       = (state_q != SCAN_IDLE);
        out_kmer_valid = (state_q == SCAN_OUT);
        out_last       = (state_q == SCAN_OUT) && is_last;
        out_frag_idx   = '0;
        if ((state_q == SCAN_ADDR) || (state_q == SCAN_WAIT) || (state_q == SCAN_OUT)) begin
            out_frag_idx = idx_q;
        end
        out_kmer       = kmer_q;
        out_kmer_pos   = kmer_pos_q;
        out_overrun    = overrun_q;
    end

endmodule

// File: tb/tb_proj_fm_scanner.sv
// Directed bench for proj_fm_scanner against a small behavioural proj_fm model.
module tb_proj_fm_scanner;

    localparam int BUF = 16;
    localparam int FL  = 8;
    localparam int IL  = 8;
    localparam int OV  = 2;

    typedef struct {
        int pos;
        int kmer;
        int last;
    } win_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, start8;
    logic          ready, ready8;
    logic          chg, chg8;
    logic [IL-1:0] frag_idx, frag_idx8;
    logic [FL-1:0] frag, frag8;
    logic [FL-1:0] kmer, kmer8;
    logic [IL-1:0] kpos, kpos8;
    logic          valid, valid8, last, last8, busy, busy8, ovr, ovr8;

    int n_chk  = 0;
    int n_fail = 0;
    int chg_cnt  = 0;
    int xfer_cnt = 0;
    win_t tbl[6];

    always #5 clk = ~clk;

    proj_fm_scanner #(.FM_BUFFER_SIZE(BUF), .FRAG_LEN(FL), .SIGNED_INDICE_LEN(IL),
                      .OVERLAP(OV), .STRIDE(2)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .out_chg_idx(chg),
        .out_frag_idx(frag_idx), .in_frag(frag), .out_kmer(kmer), .out_kmer_pos(kpos),
        .out_kmer_valid(valid), .in_kmer_ready(ready), .out_last(last),
        .out_busy(busy), .out_overrun(ovr));

    proj_fm_scanner #(.FM_BUFFER_SIZE(BUF), .FRAG_LEN(FL), .SIGNED_INDICE_LEN(IL),
                      .OVERLAP(OV), .STRIDE(8)) dut8 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start8), .out_chg_idx(chg8),
        .out_frag_idx(frag_idx8), .in_frag(frag8), .out_kmer(kmer8), .out_kmer_pos(kpos8),
        .out_kmer_valid(valid8), .in_kmer_ready(ready8), .out_last(last8),
        .out_busy(busy8), .out_overrun(ovr8));

    // proj_fm model: chg_idx promotes the filled buffer, keeping the old tail bits
    logic [15:0] fm_cur  = 16'h8000;
    logic [1:0]  fm_tail = 2'b00;

    function automatic logic [FL-1:0] fm_slice(input logic [17:0] ext, input logic [IL-1:0] idx);
        int p;
        p = int'($signed(idx)) + OV;
        if (p < 0 || p > 10) return '0;
        return ext[p +: FL];
    endfunction

    always @(posedge clk) begin
        if (chg) begin
            fm_tail <= fm_cur[15:14];
            fm_cur  <= 16'hA5C3;
        end
        frag  <= fm_slice({fm_cur, fm_tail}, frag_idx);
        frag8 <= fm_slice({16'hA5C3, 2'b10}, frag_idx8);
        if (chg) chg_cnt <= chg_cnt + 1;
        if (valid && ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = 0;
        while (!valid && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk("valid within bound", int'(valid), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " chg_idx"}, int'(chg), 0);
        chk({nm, " frag_idx"}, int'(frag_idx), 0);
        chk({nm, " kmer"}, int'(kmer), 0);
        chk({nm, " kmer_pos"}, int'(kpos), 0);
        chk({nm, " valid"}, int'(valid), 0);
        chk({nm, " last"}, int'(last), 0);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " overrun"}, int'(ovr), 0);
    endtask

    // Full scan with ready high, optionally stalling at one window or
    // pulsing a second in_start while a given window is presented.
    task automatic run_scan(input int stall_at, input int ovr_at);
        int cyc;
        int chg0, xfer0;
        chg0  = chg_cnt;
        xfer0 = xfer_cnt;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("chg_idx in swap", int'(chg), 1);
        chk("frag_idx in swap", int'($signed(frag_idx)), 0);
        chk("busy in swap", int'(busy), 1);
        tick();
        chk("chg_idx after swap", int'(chg), 0);
        chk("frag_idx in addr", int'($signed(frag_idx)), -2);
        for (int i = 0; i < 6; i++) begin
            wait_valid(8, cyc);
            if (i == 0) chk("first valid latency", cyc + 2, 4);
            else        chk("window gap", cyc + 1, 3);
            chk("kmer_pos", int'($signed(kpos)), tbl[i].pos);
            chk("kmer", int'(kmer), tbl[i].kmer);
            chk("last", int'(last), tbl[i].last);
            chk("frag_idx in out", int'($signed(frag_idx)), tbl[i].pos);
            if (tbl[i].pos == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall valid", int'(valid), 1);
                    chk("stall kmer", int'(kmer), tbl[i].kmer);
                    chk("stall pos", int'($signed(kpos)), tbl[i].pos);
                    chk("stall last", int'(last), tbl[i].last);
                end
                ready = 1'b1;
            end
            if (tbl[i].pos == ovr_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (tbl[i].pos == ovr_at) chk("overrun set", int'(ovr), 1);
        end
        chk("busy after last", int'(busy), 0);
        chk("valid after last", int'(valid), 0);
        repeat (4) tick();
        chk("no extra window", int'(valid), 0);
        chk("window count", xfer_cnt - xfer0, 6);
        chk("chg_idx pulses", chg_cnt - chg0, 1);
    endtask

    initial begin
        int cyc;
        int chg0;
        tbl[0] = '{pos: -2, kmer: 'h0E, last: 0};
        tbl[1] = '{pos:  0, kmer: 'hC3, last: 0};
        tbl[2] = '{pos:  2, kmer: 'h70, last: 0};
        tbl[3] = '{pos:  4, kmer: 'h5C, last: 0};
        tbl[4] = '{pos:  6, kmer: 'h97, last: 0};
        tbl[5] = '{pos:  8, kmer: 'hA5, last: 1};

        rst_n = 1'b0; start = 1'b0; start8 = 1'b0; ready = 1'b1; ready8 = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle busy", int'(busy), 0);

        run_scan(-100, -100);
        chk("no overrun", int'(ovr), 0);
        run_scan(4, -100);
        run_scan(-100, 2);
        tick();
        chk("overrun sticky", int'(ovr), 1);

        // Reset while window 4 is on offer
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(valid && int'($signed(kpos)) == 4) && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("reached pos 4", int'($signed(kpos)), 4);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        chg0 = chg_cnt;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no chg_idx after reset", chg_cnt - chg0, 0);
        chk("idle after reset", int'(busy), 0);
        run_scan(-100, -100);

        // Stride 8: windows -2 and 6 only
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("s8 chg_idx", int'(chg8), 1);
        repeat (3) tick();
        chk("s8 valid 0", int'(valid8), 1);
        chk("s8 pos 0", int'($signed(kpos8)), -2);
        chk("s8 kmer 0", int'(kmer8), 'h0E);
        chk("s8 last 0", int'(last8), 0);
        repeat (3) tick();
        chk("s8 valid 1", int'(valid8), 1);
        chk("s8 pos 1", int'($signed(kpos8)), 6);
        chk("s8 kmer 1", int'(kmer8), 'h97);
        chk("s8 last 1", int'(last8), 1);
        tick();
        chk("s8 busy after", int'(busy8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
